// File: rtl/kp_pkg.sv
// kp_pkg: shared definitions for the keypad entry front-end.
//   - key codes produced by the keypad decoder (0-9 are digits)
//   - controller states and error codes
//   - small helper to classify digit codes
package kp_pkg;

  localparam logic [3:0] KEY_NEG  = 4'hA;
  localparam logic [3:0] KEY_BKSP = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_DONE = 4'hD;
  localparam logic [3:0] KEY_ENT  = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic {
    S_ENTRY,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_DIGITS = 2'b01,
    ERR_FULL   = 2'b10,
    ERR_RANGE  = 2'b11
  } err_code_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: turns the raw decoded key code into single press events.
//   clock     in   system clock
//   reset     in   async, active-high
//   key_code  in   decoder output (F = no key)
//   evt       out  1-cycle pulse, one per accepted press
//   evt_code  out  key code that produced the event (valid with evt)
// A code must be seen on HOLD_CYCLES consecutive edges to count. A press
// fires only while armed; arming requires F held for HOLD_CYCLES edges, so a
// long hold or a direct switch between keys produces no extra events.
module key_debounce
  import kp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  output logic       evt,
  output logic [3:0] evt_code
);

  localparam int unsigned RW = $clog2(HOLD_CYCLES + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RUN_FULL = RW'(HOLD_CYCLES);

  logic [3:0]    prev;
  logic [RW-1:0] run;
  logic          armed;
  logic          same;
  logic          reached;

  assign same    = (key_code == prev);
  // This edge is the HOLD_CYCLES-th consecutive sample of the same code.
  assign reached = same && (run == RUN_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev     <= KEY_NONE;
      run      <= '0;
      armed    <= 1'b0;
      evt      <= 1'b0;
      evt_code <= '0;
    end else begin
      evt <= 1'b0;
      if (!same) begin
        prev <= key_code;
        run  <= RW'(1);
      end else if (run != RUN_FULL) begin
        run <= run + RW'(1);
      end
      if (reached) begin
        if (key_code == KEY_NONE) begin
          armed <= 1'b1;
        end else if (armed) begin
          evt      <= 1'b1;
          evt_code <= key_code;
          armed    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_entry_fifo.sv
// keypad_entry_fifo: keypad front-end for the linear-regression core.
// Debounced key events build signed multi-digit decimal operands which are
// committed into a DEPTH-entry FIFO; DONE drains the FIFO and then pulses
// input_done.
//   clock         in   system clock
//   reset         in   async, active-high
//   key_code      in   decoder output: 0-9 digit, A neg, B bksp, C clear,
//                      D done, E enter, F none
//   out_data      out  FIFO head operand (two's complement, 0 when empty)
//   out_valid     out  FIFO not empty
//   out_ready     in   consumer takes the head when out_valid
//   input_done    out  1-cycle pulse once DONE is accepted and FIFO drained
//   entry_mag     out  magnitude of the operand being typed
//   entry_neg     out  sign of the operand being typed
//   entry_digits  out  digits typed so far
//   count         out  FIFO occupancy
//   err           out  sticky error flag (cleared by C)
//   err_code      out  last error: 01 digit limit, 10 FIFO full, 11 range
module keypad_entry_fifo
  import kp_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH  = 12,
  parameter int unsigned MAX_DIGITS  = 3,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [3:0]                        key_code,
  output logic [ELEM_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              input_done,
  output logic [ELEM_WIDTH-2:0]             entry_mag,
  output logic                              entry_neg,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   entry_digits,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              err,
  output logic [1:0]                        err_code
);

  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned MW = ELEM_WIDTH - 1;
  // Wide enough for mag*10+9 without overflow.
  localparam int unsigned XW = ELEM_WIDTH + 4;

  localparam logic [XW-1:0] MAG_MAX    = XW'((2 ** (ELEM_WIDTH - 1)) - 1);
  localparam logic [DW-1:0] DIGITS_MAX = DW'(MAX_DIGITS);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  // Debounced key events
  logic       evt;
  logic [3:0] evt_code;

  key_debounce #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .key_code (key_code),
    .evt      (evt),
    .evt_code (evt_code)
  );

  // Controller / entry accumulator state
  state_t          state, state_next;
  logic [MW-1:0]   mag, mag_next;
  logic            neg, neg_next;
  logic [DW-1:0]   digits, digits_next;
  logic            err_q, err_next;
  err_code_t       code_q, code_next;
  logic            done_next;

  // FIFO
  logic [ELEM_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [ELEM_WIDTH-1:0] push_data;
  logic [ELEM_WIDTH-1:0] mag_ext;
  logic [XW-1:0]         appended;

  // Full is taken from the pre-pop count, so a pop in the same cycle does
  // not make room for a push.
  assign full      = (count == COUNT_FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign mag_ext   = {1'b0, mag};
  assign push_data = neg ? -mag_ext : mag_ext;
  assign appended  = XW'(mag) * XW'(10) + XW'(evt_code);

  assign entry_mag    = mag;
  assign entry_neg    = neg;
  assign entry_digits = digits;
  assign err          = err_q;
  assign err_code     = code_q;

  always_comb begin
    state_next  = state;
    mag_next    = mag;
    neg_next    = neg;
    digits_next = digits;
    err_next    = err_q;
    code_next   = code_q;
    done_next   = 1'b0;
    push        = 1'b0;

    case (state)
      S_ENTRY: begin
        if (evt) begin
          if (is_digit(evt_code)) begin
            if (digits == DIGITS_MAX) begin
              err_next  = 1'b1;
              code_next = ERR_DIGITS;
            end else if (appended > MAG_MAX) begin
              err_next  = 1'b1;
              code_next = ERR_RANGE;
            end else begin
              mag_next    = MW'(appended);
              digits_next = digits + DW'(1);
            end
          end else begin
            case (evt_code)
              KEY_NEG: begin
                if (digits != '0) neg_next = !neg;
              end
              KEY_BKSP: begin
                if (digits != '0) begin
                  mag_next    = mag / MW'(10);
                  digits_next = digits - DW'(1);
                  if (digits == DW'(1)) neg_next = 1'b0;
                end
              end
              KEY_CLR: begin
                mag_next    = '0;
                neg_next    = 1'b0;
                digits_next = '0;
                err_next    = 1'b0;
                code_next   = ERR_NONE;
              end
              KEY_ENT, KEY_DONE: begin
                // DONE commits a pending entry exactly like ENTER; a
                // rejected commit keeps DONE from starting the drain.
                if (digits != '0) begin
                  if (full) begin
                    err_next  = 1'b1;
                    code_next = ERR_FULL;
                  end else begin
                    push        = 1'b1;
                    mag_next    = '0;
                    neg_next    = 1'b0;
                    digits_next = '0;
                  end
                end
                if (evt_code == KEY_DONE && (digits == '0 || !full)) begin
                  state_next = S_DRAIN;
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_DRAIN: begin
        if (count == '0) begin
          done_next  = 1'b1;
          state_next = S_ENTRY;
        end
      end
      default: state_next = S_ENTRY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_ENTRY;
      mag        <= '0;
      neg        <= 1'b0;
      digits     <= '0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      input_done <= 1'b0;
    end else begin
      state      <= state_next;
      mag        <= mag_next;
      neg        <= neg_next;
      digits     <= digits_next;
      err_q      <= err_next;
      code_q     <= code_next;
      input_done <= done_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
